// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI master and its clock generator.
package spi_pkg;

    localparam int SPI_SS_NB = 8;
    localparam int MAX_LEN   = 32;
    localparam int DIV_W     = 16;
    localparam int LEN_W     = $clog2(MAX_LEN);
    localparam int CNT_W     = $clog2(MAX_LEN + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    // A programmed length of zero selects a full MAX_LEN-bit character.
    function automatic logic [CNT_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? CNT_W'(MAX_LEN) : CNT_W'(len);
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK generator: terminal-count down-counter toggling sclk every div+1 cycles,
// with single-cycle strobes marking the clock edge on which sclk rises or falls.
module spi_clkgen
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             sclk_o,
    output logic             pos_edge_o,
    output logic             neg_edge_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             tc;

    assign tc = (cnt_q == '0);

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (load_i) begin
            cnt_d  = div_i;
            sclk_d = 1'b0;
        end else if (en_i) begin
            if (tc) begin
                cnt_d  = div_i;
                sclk_d = ~sclk_q;
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign pos_edge_o = en_i && !load_i && tc && !sclk_q;
    assign neg_edge_o = en_i && !load_i && tc &&  sclk_q;

endmodule

// File: rtl/spi_modport.sv
// Single-clock SPI master (CPOL=0, CPHA=0): go/busy/done host side, pad-side SPI pins.
//   state | meaning
//   IDLE  | waiting for go; ss deasserted, sclk low, mosi holds last bit
//   XFER  | shifting: sample miso on sclk rise, advance mosi on sclk fall
module spi_modport
    import spi_pkg::*;
(
    input  logic                 spi_clk,
    input  logic                 spi_rst,
    input  logic                 go,
    input  logic [MAX_LEN-1:0]   tx_data,
    input  logic [LEN_W-1:0]     char_len,
    input  logic [DIV_W-1:0]     divider,
    input  logic [SPI_SS_NB-1:0] ss_sel,
    output logic [MAX_LEN-1:0]   rx_data,
    output logic                 busy,
    output logic                 done,
    output logic [SPI_SS_NB-1:0] ss_pad_o,
    output logic                 sclk_pad_o,
    output logic                 mosi_pad_o,
    input  logic                 miso_pad_i
);

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [MAX_LEN-1:0]   tx_sh_q, tx_sh_d;
    logic [MAX_LEN-1:0]   rx_sh_q, rx_sh_d;
    logic [MAX_LEN-1:0]   rx_data_q, rx_data_d;
    logic [CNT_W-1:0]     bits_q, bits_d;
    logic [SPI_SS_NB-1:0] ss_q, ss_d;
    logic                 mosi_q, mosi_d;
    logic                 done_q, done_d;
    logic                 start;
    logic                 pos_edge, neg_edge;
    logic [CNT_W-1:0]     len_e;

    assign start = go && (state_q == IDLE);
    assign len_e = eff_len(char_len);

    spi_clkgen u_clkgen (
        .clk        (spi_clk),
        .rst_n      (spi_rst),
        .en_i       (state_q == XFER),
        .load_i     (start),
        .div_i      (start ? divider : div_q),
        .sclk_o     (sclk_pad_o),
        .pos_edge_o (pos_edge),
        .neg_edge_o (neg_edge)
    );

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bits_d    = bits_q;
        ss_d      = ss_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = XFER;
                    div_d   = divider;
                    // Left-align the character so the first bit always sits at the MSB.
                    tx_sh_d = tx_data << (CNT_W'(MAX_LEN) - len_e);
                    mosi_d  = tx_sh_d[MAX_LEN-1];
                    rx_sh_d = '0;
                    bits_d  = len_e;
                    ss_d    = ~ss_sel;
                end
            end
            XFER: begin
                if (pos_edge) begin
                    rx_sh_d = {rx_sh_q[MAX_LEN-2:0], miso_pad_i};
                end
                if (neg_edge) begin
                    if (bits_q == CNT_W'(1)) begin
                        state_d   = IDLE;
                        ss_d      = '1;
                        done_d    = 1'b1;
                        rx_data_d = rx_sh_q;
                    end else begin
                        bits_d  = bits_q - CNT_W'(1);
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_q[MAX_LEN-2];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge spi_clk or negedge spi_rst) begin
        if (!spi_rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bits_q    <= '0;
            ss_q      <= '1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bits_q    <= bits_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign busy       = (state_q == XFER);
    assign done       = done_q;
    assign ss_pad_o   = ss_q;
    assign mosi_pad_o = mosi_q;

endmodule

// File: tb/tb_spi_modport.sv
// Scoreboard bench for spi_modport: directed transfers, waveform checks, async reset abort.
module tb_spi_modport;
    import spi_pkg::*;

    logic                 spi_clk = 1'b0;
    logic                 spi_rst = 1'b1;
    logic                 go = 1'b0;
    logic [MAX_LEN-1:0]   tx_data = '0;
    logic [LEN_W-1:0]     char_len = '0;
    logic [DIV_W-1:0]     divider = '0;
    logic [SPI_SS_NB-1:0] ss_sel = '0;
    logic [MAX_LEN-1:0]   rx_data;
    logic                 busy, done, sclk, mosi, miso;
    logic [SPI_SS_NB-1:0] ss_pad;

    bit   loop_en  = 1'b1;
    logic miso_val = 1'b0;
    assign miso = loop_en ? mosi : miso_val;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    always #5 spi_clk = ~spi_clk;

    spi_modport dut (
        .spi_clk    (spi_clk),
        .spi_rst    (spi_rst),
        .go         (go),
        .tx_data    (tx_data),
        .char_len   (char_len),
        .divider    (divider),
        .ss_sel     (ss_sel),
        .rx_data    (rx_data),
        .busy       (busy),
        .done       (done),
        .ss_pad_o   (ss_pad),
        .sclk_pad_o (sclk),
        .mosi_pad_o (mosi),
        .miso_pad_i (miso)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge spi_clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rx_data", rx_data, mon_e);
                chk("ss_at_done", 32'(ss_pad), 32'hFF);
                chk("busy_at_done", 32'(busy), 32'h0);
            end
        end
    end

    task automatic run(input logic [31:0] tx, input logic [4:0] len, input logic [15:0] div,
                       input logic [7:0] ss, input logic [31:0] exp_rx, input logic [31:0] exp_mosi,
                       input int nbits, input int cycles, input bit second_go);
        int d0, cyc, pulses, run_len, bad_lvl, ss_bad, guard;
        logic prev;
        logic [31:0] mw;
        d0 = done_cnt; cyc = 0; pulses = 0; run_len = 0; bad_lvl = 0; ss_bad = 0; guard = 0;
        prev = 1'b0; mw = '0;
        @(negedge spi_clk);
        tx_data = tx; char_len = len; divider = div; ss_sel = ss; go = 1'b1;
        exp_q.push_back(exp_rx);
        @(negedge spi_clk);
        go = 1'b0;
        while (busy === 1'b1 && guard < 5000) begin
            cyc++;
            if (ss_pad !== ~ss) ss_bad++;
            if (sclk === prev) run_len++;
            else begin
                if (run_len != int'(div) + 1) bad_lvl++;
                run_len = 1;
                if (sclk === 1'b1) begin
                    pulses++;
                    mw = {mw[30:0], mosi};
                end
            end
            prev = sclk;
            if (second_go && cyc == 5) begin
                tx_data = ~tx;
                go = 1'b1;
            end else go = 1'b0;
            @(negedge spi_clk);
            guard++;
        end
        go = 1'b0;
        if (run_len != int'(div) + 1) bad_lvl++;
        chk("no_timeout", 32'(guard < 5000), 32'h1);
        chk("sclk_idle_after", 32'(sclk), 32'h0);
        chk("xfer_cycles", 32'(cyc), 32'(cycles));
        chk("sclk_pulses", 32'(pulses), 32'(nbits));
        chk("mosi_bits", mw, exp_mosi);
        chk("ss_during", 32'(ss_bad), 32'h0);
        chk("sclk_levels_bad", 32'(bad_lvl), 32'h0);
        repeat (3) @(negedge spi_clk);
        chk("done_count", 32'(done_cnt - d0), 32'h1);
        chk("rx_hold", rx_data, exp_rx);
        chk("mosi_hold", 32'(mosi), 32'(exp_mosi[0]));
    endtask

    initial begin
        int d0;
        #1 spi_rst = 1'b0;
        #1;
        chk("rst_ss", 32'(ss_pad), 32'hFF);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_rx", rx_data, 32'h0);
        repeat (3) @(negedge spi_clk);
        spi_rst = 1'b1;

        loop_en = 1'b1;
        run(32'hA5, 5'd8, 16'd0, 8'h01, 32'hA5, 32'hA5, 8, 16, 1'b0);
        run(32'hC, 5'd4, 16'd3, 8'h02, 32'hC, 32'hC, 4, 32, 1'b0);
        loop_en = 1'b0; miso_val = 1'b1;
        run(32'h8000_0001, 5'd0, 16'd0, 8'h01, 32'hFFFF_FFFF, 32'h8000_0001, 32, 64, 1'b0);
        loop_en = 1'b1;
        run(32'h3C, 5'd8, 16'd1, 8'h80, 32'h3C, 32'h3C, 8, 32, 1'b1);
        run(32'h5, 5'd3, 16'd0, 8'h00, 32'h5, 32'h5, 3, 6, 1'b0);

        // Abort mid-transfer with an asynchronous reset between clock edges.
        d0 = done_cnt;
        @(negedge spi_clk);
        tx_data = 32'hAA; char_len = 5'd8; divider = 16'd2; ss_sel = 8'h01; go = 1'b1;
        @(negedge spi_clk);
        go = 1'b0;
        repeat (10) @(negedge spi_clk);
        chk("busy_before_abort", 32'(busy), 32'h1);
        #2 spi_rst = 1'b0;
        #1;
        chk("abort_ss", 32'(ss_pad), 32'hFF);
        chk("abort_sclk", 32'(sclk), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_mosi", 32'(mosi), 32'h0);
        chk("abort_rx", rx_data, 32'h0);
        repeat (3) @(negedge spi_clk);
        spi_rst = 1'b1;
        repeat (40) @(negedge spi_clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'h0);

        run(32'hFFFF_FFF3, 5'd5, 16'd2, 8'h04, 32'h13, 32'h13, 5, 30, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
